// File: rtl/lane_wr_ctrl_pkg.sv
// Shared definitions for the write-direction lane controller: FSM encoding,
// fixed pipeline offsets and the burst sequencing function.
package lane_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_BURST = 2'd2,
    ST_POST  = 2'd3
  } wr_state_t;

  localparam int OE_OFFSET   = 2;
  localparam int DATA_OFFSET = 3;

  // One register is the delay line's first stage and one is the output flop.
  localparam int EN_TAP_OFS   = OE_OFFSET - 2;
  localparam int DATA_TAP_OFS = DATA_OFFSET - 2;

  // tap_now announces a beat two cycles ahead, tap_prev the beat one cycle ahead.
  // A single idle beat between bursts goes straight BURST->PRE so data stays aligned.
  function automatic wr_state_t next_state(wr_state_t cur, logic tap_now, logic tap_prev);
    case (cur)
      ST_IDLE:  next_state = tap_now ? ST_PRE : ST_IDLE;
      ST_PRE:   next_state = ST_BURST;
      ST_BURST: begin
        if (tap_prev) begin
          next_state = ST_BURST;
        end else if (tap_now) begin
          next_state = ST_PRE;
        end else begin
          next_state = ST_POST;
        end
      end
      ST_POST:  next_state = tap_now ? ST_PRE : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lane_wr_ctrl_delay_line.sv
// Fixed-depth shift register with a runtime-selected tap at sel + OFFSET.
module wl_delay_line #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = 4,
  parameter int OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] tap
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] sr [DEPTH];
  logic [IDX_W-1:0] idx;

  assign idx = IDX_W'(sel) + IDX_W'(OFFSET);
  assign tap = sr[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sr[k] <= '0;
      end
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

endmodule

// File: rtl/lane_wr_ctrl.sv
// Write-direction lane controller: delays DFI write enable/data by the
// programmed latency and sequences DQS/DQ output enables with pre/postamble.
module lane_wr_ctrl
  import lane_wr_ctrl_pkg::*;
#(
  parameter int IOG_DQS_LANES = 2,
  parameter int LANE_DATA_W   = 16,
  parameter int WL_WIDTH      = 4
) (
  input  logic                                   SCLK,
  input  logic                                   reset,
  input  logic [WL_WIDTH-1:0]                    write_latency,
  input  logic                                   dfi_wrdata_en,
  input  logic [IOG_DQS_LANES*LANE_DATA_W-1:0]   dfi_wrdata,
  output logic [IOG_DQS_LANES-1:0]               dqs_oe_N,
  output logic [IOG_DQS_LANES-1:0]               dq_oe_N,
  output logic                                   dqs_preamble,
  output logic                                   wr_data_load,
  output logic [IOG_DQS_LANES*LANE_DATA_W-1:0]   wrdata_out
);

  localparam int DATA_W   = IOG_DQS_LANES * LANE_DATA_W;
  localparam int EN_DEPTH = 2 ** WL_WIDTH;
  localparam int DT_DEPTH = 2 ** WL_WIDTH + 2;

  logic [WL_WIDTH-1:0] wl_q;
  logic [WL_WIDTH:0]   en_age;
  logic                en_line_empty;
  logic                en_tap;
  logic                en_tap_q;
  logic [DATA_W-1:0]   data_tap;
  wr_state_t           state;
  wr_state_t           state_nxt;

  wl_delay_line #(
    .WIDTH  (1),
    .DEPTH  (EN_DEPTH),
    .SEL_W  (WL_WIDTH),
    .OFFSET (EN_TAP_OFS)
  ) u_en_line (
    .clk (SCLK),
    .rst (reset),
    .din (dfi_wrdata_en),
    .sel (wl_q),
    .tap (en_tap)
  );

  wl_delay_line #(
    .WIDTH  (DATA_W),
    .DEPTH  (DT_DEPTH),
    .SEL_W  (WL_WIDTH),
    .OFFSET (DATA_TAP_OFS)
  ) u_data_line (
    .clk (SCLK),
    .rst (reset),
    .din (dfi_wrdata),
    .sel (wl_q),
    .tap (data_tap)
  );

  // en_age counts down from the line depth after each enable; zero means the
  // enable line holds no set bit, which is exactly when wl_q may change.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      en_age <= '0;
    end else if (dfi_wrdata_en) begin
      en_age <= (WL_WIDTH+1)'(EN_DEPTH);
    end else if (en_age != '0) begin
      en_age <= en_age - (WL_WIDTH+1)'(1);
    end else begin
      en_age <= en_age;
    end
  end

  assign en_line_empty = (en_age == '0);

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      wl_q     <= '0;
      en_tap_q <= 1'b0;
    end else begin
      en_tap_q <= en_tap;
      if (state == ST_IDLE && en_line_empty) begin
        wl_q <= write_latency;
      end else begin
        wl_q <= wl_q;
      end
    end
  end

  assign state_nxt = next_state(state, en_tap, en_tap_q);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      dqs_oe_N     <= '0;
      dq_oe_N      <= '0;
      dqs_preamble <= 1'b0;
      wr_data_load <= 1'b0;
      wrdata_out   <= '0;
    end else begin
      state        <= state_nxt;
      dqs_oe_N     <= {IOG_DQS_LANES{state_nxt != ST_IDLE}};
      dq_oe_N      <= {IOG_DQS_LANES{state_nxt == ST_BURST}};
      dqs_preamble <= (state_nxt == ST_PRE);
      wr_data_load <= (state_nxt == ST_BURST);
      if (state_nxt == ST_BURST) begin
        wrdata_out <= data_tap;
      end else begin
        wrdata_out <= wrdata_out;
      end
    end
  end

endmodule

// File: tb/tb_lane_wr_ctrl.sv
// Directed bench for lane_wr_ctrl: cycle-by-cycle checks of OE/preamble/load
// and aligned write data for hand-computed burst scenarios.
module tb_lane_wr_ctrl;

  logic        SCLK = 1'b0;
  logic        reset;
  logic [3:0]  write_latency;
  logic        dfi_wrdata_en;
  logic [31:0] dfi_wrdata;
  logic [1:0]  dqs_oe_N;
  logic [1:0]  dq_oe_N;
  logic        dqs_preamble;
  logic        wr_data_load;
  logic [31:0] wrdata_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 SCLK = ~SCLK;

  lane_wr_ctrl #(
    .IOG_DQS_LANES (2),
    .LANE_DATA_W   (16),
    .WL_WIDTH      (4)
  ) dut (
    .SCLK          (SCLK),
    .reset         (reset),
    .write_latency (write_latency),
    .dfi_wrdata_en (dfi_wrdata_en),
    .dfi_wrdata    (dfi_wrdata),
    .dqs_oe_N      (dqs_oe_N),
    .dq_oe_N       (dq_oe_N),
    .dqs_preamble  (dqs_preamble),
    .wr_data_load  (wr_data_load),
    .wrdata_out    (wrdata_out)
  );

  // Start of a new cycle: just after the rising edge.
  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  task automatic settle(input logic [3:0] wl);
    write_latency = wl;
    dfi_wrdata_en = 1'b0;
    dfi_wrdata    = 32'h0;
    repeat (20) step();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    reset         = 1'b1;
    write_latency = 4'd0;
    dfi_wrdata_en = 1'b0;
    dfi_wrdata    = 32'h0;
    repeat (3) @(negedge SCLK);
    obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
    n_cmp++;
    if (obs !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b want %b", obs, 6'b0);
    end
    n_cmp++;
    if (wrdata_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data got %h want %h", wrdata_out, 32'h0);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic_burst();
    logic [5:0]  obs, exp;
    logic [31:0] exp_d;
    logic        oe, ld;
    settle(4'd4);
    for (int c = 0; c < 26; c++) begin
      step();
      dfi_wrdata_en = (c >= 10 && c <= 13);
      dfi_wrdata    = (c >= 10 && c <= 13) ? {8{4'(c - 9)}} : 32'hFFFF_0000;
      @(negedge SCLK);
      oe  = (c >= 16 && c <= 21);
      ld  = (c >= 17 && c <= 20);
      exp = {{2{oe}}, {2{ld}}, (c == 16), ld};
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL basic_ctl c=%0d got %b want %b", c, obs, exp);
      end
      if (c >= 17) begin
        exp_d = (c <= 20) ? {8{4'(c - 16)}} : 32'h4444_4444;
        n_cmp++;
        if (wrdata_out !== exp_d) begin
          n_err++;
          $display("FAIL basic_data c=%0d got %h want %h", c, wrdata_out, exp_d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  obs, exp;
    logic [31:0] exp_d;
    logic        oe, ld, en;
    settle(4'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      en            = (c == 0 || c == 1 || c == 3 || c == 4);
      dfi_wrdata_en = en;
      dfi_wrdata    = en ? (32'hA5A5_0000 | 32'(c)) : 32'h0;
      @(negedge SCLK);
      oe  = (c >= 2 && c <= 8);
      ld  = (c == 3 || c == 4 || c == 6 || c == 7);
      exp = {{2{oe}}, {2{ld}}, (c == 2 || c == 5), ld};
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL b2b_ctl c=%0d got %b want %b", c, obs, exp);
      end
      if (ld) begin
        exp_d = 32'hA5A5_0000 | 32'(c - 3);
        n_cmp++;
        if (wrdata_out !== exp_d) begin
          n_err++;
          $display("FAIL b2b_data c=%0d got %h want %h", c, wrdata_out, exp_d);
        end
      end
    end
  endtask

  task automatic test_max_latency();
    logic [5:0]  obs, exp;
    logic        oe, ld;
    settle(4'd15);
    for (int c = 0; c < 24; c++) begin
      step();
      dfi_wrdata_en = (c == 0);
      dfi_wrdata    = (c == 0) ? 32'hDEAD_BEEF : 32'(c);
      @(negedge SCLK);
      oe  = (c >= 17 && c <= 19);
      ld  = (c == 18);
      exp = {{2{oe}}, {2{ld}}, (c == 17), ld};
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL maxwl_ctl c=%0d got %b want %b", c, obs, exp);
      end
      if (c >= 18) begin
        n_cmp++;
        if (wrdata_out !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL maxwl_data c=%0d got %h want %h", c, wrdata_out, 32'hDEAD_BEEF);
        end
      end
    end
  endtask

  task automatic test_latency_change();
    logic [5:0]  obs, exp;
    logic [31:0] exp_d;
    logic        oe, ld, en;
    settle(4'd2);
    for (int c = 0; c < 38; c++) begin
      step();
      en            = (c == 0 || c == 1 || c == 25);
      dfi_wrdata_en = en;
      dfi_wrdata    = 32'h2222_0000 | 32'(c);
      write_latency = (c >= 1) ? 4'd6 : 4'd2;
      @(negedge SCLK);
      oe  = (c >= 4 && c <= 7) || (c >= 33 && c <= 35);
      ld  = (c == 5 || c == 6 || c == 34);
      exp = {{2{oe}}, {2{ld}}, (c == 4 || c == 33), ld};
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL wlchg_ctl c=%0d got %b want %b", c, obs, exp);
      end
      if (ld) begin
        exp_d = (c == 34) ? 32'h2222_0019 : (32'h2222_0000 | 32'(c - 5));
        n_cmp++;
        if (wrdata_out !== exp_d) begin
          n_err++;
          $display("FAIL wlchg_data c=%0d got %h want %h", c, wrdata_out, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] obs, exp;
    logic       oe, ld;
    settle(4'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      dfi_wrdata_en = (c <= 3);
      dfi_wrdata    = 32'h5555_0000 | 32'(c);
      @(negedge SCLK);
      oe  = (c >= 3);
      ld  = (c >= 4);
      exp = {{2{oe}}, {2{ld}}, (c == 3), ld};
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL rstmid_pre c=%0d got %b want %b", c, obs, exp);
      end
    end
    #1;
    reset = 1'b1;
    #1;
    obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
    n_cmp++;
    if (obs !== 6'b0 || wrdata_out !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async got %b/%h want %b/%h", obs, wrdata_out, 6'b0, 32'h0);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      @(negedge SCLK);
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== 6'b0 || wrdata_out !== 32'h0) begin
        n_err++;
        $display("FAIL rstmid_after c=%0d got %b/%h want %b/%h", c, obs, wrdata_out, 6'b0, 32'h0);
      end
    end
  endtask

  task automatic test_single_beats();
    logic [5:0]  obs, exp;
    logic [31:0] exp_d;
    logic        oe, ld, en;
    settle(4'd3);
    for (int c = 0; c < 18; c++) begin
      step();
      en            = (c == 0 || c == 3 || c == 6);
      dfi_wrdata_en = en;
      dfi_wrdata    = en ? (32'h6600_0000 | 32'(c)) : 32'h0;
      @(negedge SCLK);
      oe  = (c >= 5 && c <= 13);
      ld  = (c == 6 || c == 9 || c == 12);
      exp = {{2{oe}}, {2{ld}}, (c == 5 || c == 8 || c == 11), ld};
      obs = {dqs_oe_N, dq_oe_N, dqs_preamble, wr_data_load};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL single_ctl c=%0d got %b want %b", c, obs, exp);
      end
      if (ld) begin
        exp_d = 32'h6600_0000 | 32'(c - 6);
        n_cmp++;
        if (wrdata_out !== exp_d) begin
          n_err++;
          $display("FAIL single_data c=%0d got %h want %h", c, wrdata_out, exp_d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_back_to_back();
    test_max_latency();
    test_latency_change();
    test_reset_mid_burst();
    test_single_beats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
